// File: rtl/scpu_irq_pkg.sv
// scpu_irq_pkg: shared definitions for the interrupt controller.
//   IRQ_N        number of interrupt sources
//   VEC_BASE_DEF default vector address of source 0
//   irq_state_t  controller FSM states
//   lowest_idx   index of the lowest set bit (source 0 = highest priority)
package scpu_irq_pkg;

  localparam int IRQ_N = 4;
  localparam logic [9:0] VEC_BASE_DEF = 10'h3F0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  function automatic logic [1:0] lowest_idx(input logic [IRQ_N-1:0] v);
    lowest_idx = 2'd0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: per-bit two-flop synchronizer for asynchronous interrupt lines.
//   i_clock  system clock
//   i_reset  synchronous active-high reset (clears both stages)
//   i_d      asynchronous input bits
//   o_q      synchronized bits, two cycles behind i_d
module irq_sync #(
  parameter int W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: single-level (non-nesting) priority interrupt controller.
// Rising edges on irq are latched into pending; the lowest-index pending
// and enabled source is offered to the control unit, which accepts it with
// int_ack and ends the handler with int_ret.
//   clock, reset      system clock, synchronous active-high reset
//   irq[3:0]          level interrupt sources (rising edge significant)
//   mask_we, mask_in  enable-mask write strobe and value
//   int_ack, int_ret  accept offered interrupt / return from interrupt
//   int_req           interrupt offered
//   int_id, vector    offered/in-service source and its jump target
//   pending           latched, unacknowledged edges
//   in_service        handler running
// Build option: define IRQ_SYNC_EN to pass irq through a two-flop
// synchronizer (irq_sync) before edge detection.
module irq_ctrl
  import scpu_irq_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      irq,
  input  logic            mask_we,
  input  logic [3:0]      mask_in,
  input  logic            int_ack,
  input  logic            int_ret,
  output logic            int_req,
  output logic [1:0]      int_id,
  output logic [PC_W-1:0] vector,
  output logic [3:0]      pending,
  output logic            in_service
);

  logic [IRQ_N-1:0] w_irq;
  logic [IRQ_N-1:0] w_edge;
  logic [IRQ_N-1:0] w_elig;
  logic [IRQ_N-1:0] w_clr;
  logic [1:0]       w_win_id;
  logic             w_latch;
  logic             w_clr_en;

  logic [IRQ_N-1:0] r_irq_q;
  logic [IRQ_N-1:0] r_pending;
  logic [IRQ_N-1:0] r_mask;
  logic [1:0]       r_int_id;
  logic [PC_W-1:0]  r_vector;
  logic [1:0]       r_arm_cnt;
  logic             w_armed;

  irq_state_t r_state;
  irq_state_t w_state_nx;

  // Edge detection is held off until irq_q has captured the post-reset level
  // of irq, so a line already high at reset release does not count as an edge.
`ifdef IRQ_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;

  irq_sync #(.W(IRQ_N)) u_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_d     (irq),
    .o_q     (w_irq)
  );
`else
  localparam logic [1:0] ARM_CYC = 2'd1;

  assign w_irq = irq;
`endif

  assign w_armed  = (r_arm_cnt == ARM_CYC);
  assign w_edge   = w_irq & ~r_irq_q & {IRQ_N{w_armed}};
  assign w_elig   = r_pending & r_mask;
  assign w_win_id = lowest_idx(w_elig);
  assign w_clr    = w_clr_en ? (IRQ_N'(1) << r_int_id) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_arm_cnt <= 2'd0;
      r_irq_q   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
      r_irq_q <= w_irq;
      // New edge wins over a same-cycle acknowledge clear.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) r_mask <= mask_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_int_id <= 2'd0;
      r_vector <= VEC_BASE;
    end else begin
      r_state <= w_state_nx;
      if (w_latch) begin
        r_int_id <= w_win_id;
        r_vector <= VEC_BASE + PC_W'({w_win_id, 2'b00});
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_latch    = 1'b0;
    w_clr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nx = ST_REQ;
          w_latch    = 1'b1;
        end
      end
      // The offer is frozen here; no re-arbitration until back in IDLE.
      ST_REQ: begin
        if (int_ack) begin
          w_state_nx = ST_SERVICE;
          w_clr_en   = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (int_ret) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign int_req    = (r_state == ST_REQ);
  assign in_service = (r_state == ST_SERVICE);
  assign int_id     = r_int_id;
  assign vector     = r_vector;
  assign pending    = r_pending;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       int_ack;
  logic       int_ret;
  logic       int_req;
  logic [1:0] int_id;
  logic [9:0] vector;
  logic [3:0] pending;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.PC_W(10), .VEC_BASE(10'h3F0)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .int_req    (int_req),
    .int_id     (int_id),
    .vector     (vector),
    .pending    (pending),
    .in_service (in_service)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic srv,
                           input logic [1:0] id, input logic [9:0] vec, input logic [3:0] pend);
    check({tag, ".int_req"}, 32'(int_req), 32'(req));
    check({tag, ".in_service"}, 32'(in_service), 32'(srv));
    check({tag, ".int_id"}, 32'(int_id), 32'(id));
    check({tag, ".vector"}, 32'(vector), 32'(vec));
    check({tag, ".pending"}, 32'(pending), 32'(pend));
  endtask

  initial begin
    reset = 1'b1; irq = 4'h0; mask_we = 1'b0; mask_in = 4'h0;
    int_ack = 1'b0; int_ret = 1'b0;
    tick(); tick();
    check_all("reset", 1'b0, 1'b0, 2'd0, 10'h3F0, 4'h0);
    reset = 1'b0;
    tick();

    // single source, mask all
    mask_we = 1'b1; mask_in = 4'hF; tick(); mask_we = 1'b0;
    irq = 4'b0100; tick();
    check_all("single.pend", 1'b0, 1'b0, 2'd0, 10'h3F0, 4'b0100);
    tick();
    check_all("single.req", 1'b1, 1'b0, 2'd2, 10'h3F8, 4'b0100);

    // higher-priority edge during REQ does not change the offer
    irq = 4'b0101; tick();
    check_all("frozen", 1'b1, 1'b0, 2'd2, 10'h3F8, 4'b0101);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_all("svc2", 1'b0, 1'b1, 2'd2, 10'h3F8, 4'b0001);
    tick(); tick();
    check_all("svc2.noreq", 1'b0, 1'b1, 2'd2, 10'h3F8, 4'b0001);
    // return with eligible pending: IDLE first, then REQ
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    check_all("ret2.idle", 1'b0, 1'b0, 2'd2, 10'h3F8, 4'b0001);
    tick();
    check_all("ret2.req0", 1'b1, 1'b0, 2'd0, 10'h3F0, 4'b0001);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_all("svc0", 1'b0, 1'b1, 2'd0, 10'h3F0, 4'b0000);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    irq = 4'h0; tick();
    check_all("idle0", 1'b0, 1'b0, 2'd0, 10'h3F0, 4'b0000);

    // simultaneous edges on 3 and 1
    irq = 4'b1010; tick();
    check("dual.pend", 32'(pending), 32'h0000000A);
    tick();
    check_all("dual.req1", 1'b1, 1'b0, 2'd1, 10'h3F4, 4'b1010);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_all("dual.svc1", 1'b0, 1'b1, 2'd1, 10'h3F4, 4'b1000);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    check("dual.ret", 32'(in_service), 32'h0);
    tick();
    check_all("dual.req3", 1'b1, 1'b0, 2'd3, 10'h3FC, 4'b1000);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    irq = 4'h0; tick();
    check_all("dual.done", 1'b0, 1'b0, 2'd3, 10'h3FC, 4'b0000);

    // ignored ack in IDLE, ignored ret in REQ, set-wins on ack
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_all("ack.idle", 1'b0, 1'b0, 2'd3, 10'h3FC, 4'b0000);
    irq = 4'b0010; tick(); tick();
    check_all("req1", 1'b1, 1'b0, 2'd1, 10'h3F4, 4'b0010);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    check_all("ret.inreq", 1'b1, 1'b0, 2'd1, 10'h3F4, 4'b0010);
    irq = 4'h0; tick();
    irq = 4'b0010; int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_all("setwins", 1'b0, 1'b1, 2'd1, 10'h3F4, 4'b0010);
    // repeated edge on an already-pending bit collapses
    irq = 4'h0; tick(); irq = 4'b0010; tick();
    check("collapse", 32'(pending), 32'h2);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    tick();
    check_all("req1b", 1'b1, 1'b0, 2'd1, 10'h3F4, 4'b0010);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    irq = 4'h0; tick();
    check("clean", 32'(pending), 32'h0);

    // masked source stays pending, offered after unmask
    mask_we = 1'b1; mask_in = 4'h0; tick(); mask_we = 1'b0;
    irq = 4'b0001; tick();
    check_all("masked.pend", 1'b0, 1'b0, 2'd1, 10'h3F4, 4'b0001);
    tick(); tick();
    check("masked.noreq", 32'(int_req), 32'h0);
    mask_we = 1'b1; mask_in = 4'h1; tick(); mask_we = 1'b0;
    check("unmask.1", 32'(int_req), 32'h0);
    tick();
    check_all("unmask.req", 1'b1, 1'b0, 2'd0, 10'h3F0, 4'b0001);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("svc.m", 32'(in_service), 32'h1);

    // reset during SERVICE with pending 0110
    irq = 4'b0111; tick();
    check_all("pre.rst", 1'b0, 1'b1, 2'd0, 10'h3F0, 4'b0110);
    reset = 1'b1; tick();
    check_all("midrst", 1'b0, 1'b0, 2'd0, 10'h3F0, 4'b0000);
    // irq still high at release: no edge
    reset = 1'b0; tick(); tick(); tick();
    check("nohigh.edge", 32'(pending), 32'h0);
    irq = 4'h0; tick();
    irq = 4'b0100; tick();
    check("post.pend", 32'(pending), 32'h4);
    tick(); tick();
    check("post.mask0", 32'(int_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The module SHALL have parameter PC_W, default 10, the width of the vector output (instruction address width).
REQ-002 The module SHALL have parameter VEC_BASE, default 10'h3F0, the vector address of source 0.
REQ-003 Port clock  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port irq  input  4  level interrupt sources; only rising edges are significant.
REQ-006 Port mask_we  input  1  write strobe for the enable mask.
REQ-007 Port mask_in  input  4  new enable mask; bit=1 enables that source.
REQ-008 Port int_ack  input  1  control unit accepts the offered interrupt at an instruction boundary.
REQ-009 Port int_ret  input  1  control unit executes return-from-interrupt.
REQ-010 Port int_req  output  1  interrupt offered to the control unit.
REQ-011 Port int_id  output  2  index of the offered or in-service source.
REQ-012 Port vector  output  PC_W  jump target, VEC_BASE + 4*int_id, modulo 2^PC_W.
REQ-013 Port pending  output  4  latched, not-yet-acknowledged edges.
REQ-014 Port in_service  output  1  a handler is running.

Function
REQ-015 irq SHALL be registered each cycle into irq_q; edge[i] = irq[i] & ~irq_q[i].
REQ-016 An edge on source i SHALL set pending[i] on the same clock edge (pending visible 1 cycle after irq first sampled high).
REQ-017 The FSM SHALL have states IDLE, REQ, SERVICE.
REQ-018 IDLE -> REQ when (pending & mask) != 0; winner = lowest-index eligible bit (source 0 highest priority); int_id and vector latched on this transition; int_req=1 from the next cycle.
REQ-019 In REQ, int_id/vector SHALL stay frozen; later higher-priority edges or mask changes SHALL NOT withdraw or change the offer.
REQ-020 REQ -> SERVICE on int_ack: clear pending[int_id], int_req=0, in_service=1 from the next cycle.
REQ-021 SERVICE -> IDLE on int_ret; in_service=0 next cycle; no nesting: no int_req while in SERVICE.
REQ-022 int_ack outside REQ and int_ret outside SERVICE SHALL be ignored.
REQ-023 A new edge on bit i coinciding with its clear by int_ack SHALL leave pending[i]=1 (set wins).
REQ-024 Edges arriving during REQ/SERVICE SHALL be latched in pending; repeated edges on an already-pending bit SHALL collapse to one.
REQ-025 mask_we SHALL update mask on the next edge; masking a pending source SHALL keep its pending bit, only making it ineligible.
REQ-026 With int_ret and an eligible pending bit in the same cycle, the FSM SHALL go to IDLE, then REQ the following cycle.

Reset
REQ-027 On reset: state=IDLE, irq_q=0, pending=0, mask=4'b0000, int_req=0, in_service=0, int_id=0, vector=VEC_BASE.
REQ-028 Reset SHALL win over all inputs, including mid-REQ or mid-SERVICE, discarding any pending or in-service interrupt.
REQ-029 If irq is already high at reset release, no edge SHALL be detected until irq falls and rises again (irq_q captures irq from the first post-reset cycle).

Configuration
REQ-030 Macro IRQ_SYNC_EN defined: each irq bit SHALL pass through a 2-flop synchronizer before edge detection (pending latency 3 cycles); undefined: irq used directly (latency 1).

Structure
REQ-031 Package scpu_irq_pkg SHALL hold the FSM state enum, IRQ_N=4, and the default VEC_BASE.
REQ-032 The synchronizer SHALL be sub-module irq_sync, instantiated only under IRQ_SYNC_EN.

Verification
REQ-033 mask=4'hF, irq[2] 0->1 -> pending=4'b0100 next cycle, int_req=1 one cycle later, int_id=2, vector=10'h3F8.
REQ-034 mask=4'hF, irq[3] and irq[1] rise together -> int_id=1, vector=10'h3F4; after int_ack, pending=4'b1000; after int_ret, second offer with int_id=3, vector=10'h3FC.
REQ-035 mask=4'h0, irq[0] rises -> pending=4'b0001, int_req stays 0; write mask=4'h1 -> int_req=1 two cycles later.
REQ-036 In REQ (int_id=2), irq[0] rises -> int_id stays 2; int_ack -> SERVICE; pending=4'b0001, no int_req until int_ret.
REQ-037 Assert reset during SERVICE with pending=4'b0110 -> next cycle all outputs at reset values, mask=0.
REQ-038 int_ack in IDLE and int_ret in REQ -> no state change; same-cycle irq[1] edge and int_ack of id 1 -> pending[1]=1.
